// File: rtl/alu_exec_pkg.sv
// Shared types for the accumulator-core execute stage: ALU op codes and instruction classes.
// Optional feature macro: ALU_EXEC_ZERO_FLAG_EN (adds the registered zero flag).
package alu_exec_pkg;

    typedef enum logic [3:0] {
        OP_PASSW = 4'b0000,
        OP_CLR   = 4'b0001,
        OP_SUB   = 4'b0010,
        OP_DEC   = 4'b0011,
        OP_IOR   = 4'b0100,
        OP_AND   = 4'b0101,
        OP_XOR   = 4'b0110,
        OP_ADD   = 4'b0111,
        OP_MOV   = 4'b1000,
        OP_COM   = 4'b1001,
        OP_INC   = 4'b1010,
        OP_BCF   = 4'b1011,
        OP_RRF   = 4'b1100,
        OP_RLF   = 4'b1101,
        OP_SWAP  = 4'b1110,
        OP_BSF   = 4'b1111
    } op_e;

    localparam logic [1:0] CLASS_BYTE = 2'b00;
    localparam logic [1:0] CLASS_BIT  = 2'b01;
    localparam logic [1:0] CLASS_RSVD = 2'b10;
    localparam logic [1:0] CLASS_LIT  = 2'b11;

    // True for ops whose result updates the zero flag (when that flag is built).
    function automatic logic op_writes_zero(input op_e op);
        case (op)
            OP_PASSW, OP_BCF, OP_BSF, OP_RRF, OP_RLF: return 1'b0;
            default:                                  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Operand/result bundle between fetch/W-register logic (master) and alu_exec (slave).
// Carries the zero flag only when ALU_EXEC_ZERO_FLAG_EN is defined.
interface alu_exec_if;
    logic [7:0] inst_reg;
    logic [7:0] f;
    logic [7:0] k;
    logic [7:0] w;
    logic [3:0] inst;
    logic       d;
    logic [2:0] bit_number;
    logic       switch_a_m;
    logic [7:0] b;
    logic [7:0] ans;
    logic       carry;
`ifdef ALU_EXEC_ZERO_FLAG_EN
    logic       zero;
`endif

    modport master (
        output inst_reg, f, k, w,
        input  inst, d, bit_number, switch_a_m, b, ans, carry
`ifdef ALU_EXEC_ZERO_FLAG_EN
        , input zero
`endif
    );

    modport slave (
        input  inst_reg, f, k, w,
        output inst, d, bit_number, switch_a_m, b, ans, carry
`ifdef ALU_EXEC_ZERO_FLAG_EN
        , output zero
`endif
    );
endinterface

// File: rtl/alu_exec_decode.sv
// Combinational instruction decoder: inst_reg -> ALU op, destination, bit index, B-operand select.
import alu_exec_pkg::*;

module alu_exec_decode (
    input  logic [7:0] inst_reg,
    output op_e        inst,
    output logic       d,
    output logic [2:0] bit_number,
    output logic       switch_a_m
);

    logic unused_bit0;
    assign unused_bit0 = inst_reg[0];

    assign bit_number = inst_reg[3:1];

    always_comb begin
        inst       = OP_PASSW;
        d          = 1'b0;
        switch_a_m = 1'b0;
        case (inst_reg[7:6])
            CLASS_BYTE: begin
                d = inst_reg[1];
                // Two byte-op encodings alias onto DEC/INC rather than the bit-op codes.
                case (inst_reg[5:2])
                    4'b1011: inst = OP_DEC;
                    4'b1111: inst = OP_INC;
                    default: inst = op_e'(inst_reg[5:2]);
                endcase
            end
            CLASS_BIT: begin
                d = 1'b1;
                case (inst_reg[5:4])
                    2'b00:   inst = OP_BCF;
                    2'b01:   inst = OP_BSF;
                    default: inst = OP_MOV;
                endcase
            end
            CLASS_LIT: begin
                switch_a_m = 1'b1;
                casez (inst_reg[5:2])
                    4'b00??: inst = OP_MOV;
                    4'b1000: inst = OP_IOR;
                    4'b1001: inst = OP_AND;
                    4'b1010: inst = OP_XOR;
                    4'b110?: inst = OP_SUB;
                    4'b111?: inst = OP_ADD;
                    default: inst = OP_MOV;
                endcase
            end
            default: begin
                inst = OP_PASSW;
            end
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// Execute stage of the 8-bit W core: decode, B-operand mux, ALU and carry flag.
// ALU_EXEC_ZERO_FLAG_EN adds a registered zero flag on the bus.
import alu_exec_pkg::*;

module alu_exec (
    input  logic        clk,
    input  logic        reset,
    alu_exec_if.slave   bus
);

    op_e        op;
    logic       d;
    logic [2:0] bit_number;
    logic       switch_a_m;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] mask;
    logic [8:0] sum9;
    logic [8:0] diff9;
    logic [7:0] res;
    logic [7:0] ans;
    logic       carry_d;
    logic       carry_q;

    alu_exec_decode u_decode (
        .inst_reg   (bus.inst_reg),
        .inst       (op),
        .d          (d),
        .bit_number (bit_number),
        .switch_a_m (switch_a_m)
    );

    assign a     = bus.w;
    assign b     = switch_a_m ? bus.k : bus.f;
    assign mask  = 8'b0000_0001 << bit_number;
    assign sum9  = {1'b0, a} + {1'b0, b};
    assign diff9 = {1'b0, b} - {1'b0, a};

    always_comb begin
        res     = '0;
        carry_d = carry_q;
        case (op)
            OP_PASSW: res = a;
            OP_CLR:   res = '0;
            OP_SUB: begin
                res     = diff9[7:0];
                carry_d = ~diff9[8];
            end
            OP_DEC:   res = b - 8'd1;
            OP_IOR:   res = a | b;
            OP_AND:   res = a & b;
            OP_XOR:   res = a ^ b;
            OP_ADD: begin
                res     = sum9[7:0];
                carry_d = sum9[8];
            end
            OP_MOV:   res = b;
            OP_COM:   res = ~b;
            OP_INC:   res = b + 8'd1;
            OP_BCF:   res = b & ~mask;
            OP_RRF: begin
                res     = {carry_q, b[7:1]};
                carry_d = b[0];
            end
            OP_RLF: begin
                res     = {b[6:0], carry_q};
                carry_d = b[7];
            end
            OP_SWAP:  res = {b[3:0], b[7:4]};
            OP_BSF:   res = b | mask;
            default:  res = '0;
        endcase
    end

    assign ans = reset ? '0 : res;

    always_ff @(posedge clk) begin
        if (reset) carry_q <= 1'b0;
        else       carry_q <= carry_d;
    end

`ifdef ALU_EXEC_ZERO_FLAG_EN
    logic zero_d;
    logic zero_q;

    always_comb begin
        zero_d = zero_q;
        if (op_writes_zero(op)) zero_d = (ans == 8'h00);
    end

    always_ff @(posedge clk) begin
        if (reset) zero_q <= 1'b0;
        else       zero_q <= zero_d;
    end

    assign bus.zero = zero_q;
`endif

    assign bus.inst       = op;
    assign bus.d          = d;
    assign bus.bit_number = bit_number;
    assign bus.switch_a_m = switch_a_m;
    assign bus.b          = b;
    assign bus.ans        = ans;
    assign bus.carry      = carry_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed-vector bench for alu_exec; expected values are hand-computed from the instruction set.
module tb_alu_exec;

    logic clk;
    logic reset;
    int unsigned n_cmp;
    int unsigned n_err;

    alu_exec_if bus ();

    alu_exec dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] ir, input logic [7:0] fv,
                         input logic [7:0] kv, input logic [7:0] wv);
        @(negedge clk);
        bus.inst_reg = ir;
        bus.f        = fv;
        bus.k        = kv;
        bus.w        = wv;
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.inst_reg = 8'h00;
        bus.f = '0;
        bus.k = '0;
        bus.w = '0;

        // Reset with ADD on the bus, then set carry.
        drive(8'h1D, 8'hFF, 8'h00, 8'h01);
        check("rst_ans0", bus.ans, 8'h00);
        edge_step();
        check("rst_carry0", bus.carry, 1'b0);
`ifdef ALU_EXEC_ZERO_FLAG_EN
        check("rst_zero0", bus.zero, 1'b0);
`endif
        reset = 1'b0;
        drive(8'h1D, 8'hFF, 8'h00, 8'h01);
        edge_step();
        check("pre_carry1", bus.carry, 1'b1);

        // Reset beats a coinciding carry-writing ADD; decode unaffected.
        reset = 1'b1;
        drive(8'h1D, 8'h10, 8'h00, 8'hF5);
        check("rst_ans_forced", bus.ans, 8'h00);
        check("rst_inst_decode", bus.inst, 4'b0111);
        edge_step();
        check("rst_wins_carry", bus.carry, 1'b0);
        reset = 1'b0;

        // ADDWF
        drive(8'h1D, 8'd10, 8'h00, 8'd5);
        check("add_inst", bus.inst, 4'b0111);
        check("add_d", bus.d, 1'b0);
        check("add_b", bus.b, 8'd10);
        check("add_ans", bus.ans, 8'd15);
        edge_step();
        check("add_carry0", bus.carry, 1'b0);
`ifdef ALU_EXEC_ZERO_FLAG_EN
        check("add_zero0", bus.zero, 1'b0);
`endif
        drive(8'h1D, 8'hFF, 8'h00, 8'h01);
        check("add_wrap_ans", bus.ans, 8'h00);
        edge_step();
        check("add_wrap_carry", bus.carry, 1'b1);
`ifdef ALU_EXEC_ZERO_FLAG_EN
        check("add_wrap_zero", bus.zero, 1'b1);
`endif

        // Literal MOV holds carry
        drive(8'hC0, 8'h55, 8'h01, 8'h77);
        check("movlw_sel", bus.switch_a_m, 1'b1);
        check("movlw_b", bus.b, 8'h01);
        check("movlw_ans", bus.ans, 8'h01);
        edge_step();
        check("movlw_hold_carry", bus.carry, 1'b1);

        // Clear carry, then ADDLW wrap
        drive(8'h1D, 8'd10, 8'h00, 8'd5);
        edge_step();
        check("clr_carry", bus.carry, 1'b0);
        drive(8'hF8, 8'h00, 8'h01, 8'hFF);
        check("addlw_ans", bus.ans, 8'h00);
        edge_step();
        check("addlw_carry", bus.carry, 1'b1);

        // IORLW
        drive(8'hE0, 8'h00, 8'h0F, 8'hF0);
        check("iorlw_inst", bus.inst, 4'b0100);
        check("iorlw_ans", bus.ans, 8'hFF);

        // Bit ops
        drive(8'h52, 8'h00, 8'h00, 8'h00);
        check("bsf_bitnum", bus.bit_number, 3'd1);
        check("bsf_inst", bus.inst, 4'b1111);
        check("bsf_d", bus.d, 1'b1);
        check("bsf_ans", bus.ans, 8'h02);
        drive(8'h42, 8'hFF, 8'h00, 8'h00);
        check("bcf_ans", bus.ans, 8'hFD);
        drive(8'h4E, 8'h00, 8'h00, 8'h00);
        check("bsf7_inst_bcf", bus.inst, 4'b1011);
        drive(8'h5E, 8'h00, 8'h00, 8'h00);
        check("bsf7_ans", bus.ans, 8'h80);

        // Rotates through carry
        drive(8'h1D, 8'h01, 8'h00, 8'h01);
        edge_step();
        check("rot_pre_carry0", bus.carry, 1'b0);
        drive(8'h34, 8'h81, 8'h00, 8'h00);
        check("rlf_ans", bus.ans, 8'h02);
        edge_step();
        check("rlf_carry", bus.carry, 1'b1);
        drive(8'h30, 8'h01, 8'h00, 8'h00);
        check("rrf_ans", bus.ans, 8'h80);
        edge_step();
        check("rrf_carry", bus.carry, 1'b1);
        drive(8'h30, 8'h02, 8'h00, 8'h00);
        check("rrf2_ans", bus.ans, 8'h81);
        edge_step();
        check("rrf2_carry", bus.carry, 1'b0);

        // SUBWF
        drive(8'h09, 8'd10, 8'h00, 8'd3);
        check("sub_inst", bus.inst, 4'b0010);
        check("sub_ans", bus.ans, 8'd7);
        edge_step();
        check("sub_carry", bus.carry, 1'b1);
        drive(8'h09, 8'd10, 8'h00, 8'd11);
        check("sub_neg_ans", bus.ans, 8'hFF);
        edge_step();
        check("sub_neg_carry", bus.carry, 1'b0);
        drive(8'h09, 8'd10, 8'h00, 8'd10);
        check("sub_eq_ans", bus.ans, 8'h00);
        edge_step();
        check("sub_eq_carry", bus.carry, 1'b1);

        // SWAPF, CLRF, DEC/INC aliases
        drive(8'h39, 8'hA5, 8'h00, 8'h00);
        check("swap_ans", bus.ans, 8'h5A);
        drive(8'h07, 8'h33, 8'h00, 8'h44);
        check("clr_ans", bus.ans, 8'h00);
        check("clr_d", bus.d, 1'b1);
        drive(8'h2C, 8'h00, 8'h00, 8'h00);
        check("dec_inst", bus.inst, 4'b0011);
        check("dec_ans", bus.ans, 8'hFF);
        drive(8'h3C, 8'hFF, 8'h00, 8'h00);
        check("inc_inst", bus.inst, 4'b1010);
        check("inc_ans", bus.ans, 8'h00);
        edge_step();
        check("inc_hold_carry", bus.carry, 1'b1);

        // Class 10 passes W
        drive(8'h80, 8'h12, 8'h34, 8'h9C);
        check("cls10_inst", bus.inst, 4'b0000);
        check("cls10_ans", bus.ans, 8'h9C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
